// File: rtl/shift_line.sv
// Parameterised bidirectional shift line with parallel load, a clamped tap select
// and a fill counter that reports when the selected tap holds written data.
module shift_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [WIDTH*DEPTH-1:0]   load_data,
    input  logic [TW-1:0]            tap_sel,
    output logic [WIDTH-1:0]         data_out,
    output logic [WIDTH-1:0]         last_out,
    output logic [WIDTH-1:0]         first_out,
    output logic [WIDTH*DEPTH-1:0]   par_out,
    output logic [TW:0]              fill_count,
    output logic                     primed
);

    localparam int unsigned LAST = DEPTH - 1;
    localparam logic [TW:0] FULL = (TW+1)'(DEPTH);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [TW:0]      fill_q;
    logic [TW:0]      fill_d;
    logic [TW-1:0]    tap_k;

    // Next-state: clear beats enable, enable gates every mode.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        fill_d = fill_q;

        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
            fill_d = '0;
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    stage_d[0] = data_in;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                    if (fill_q != FULL) begin
                        fill_d = fill_q + (TW+1)'(1);
                    end
                end
                MODE_DOWN: begin
                    stage_d[LAST] = data_in;
                    for (int unsigned i = 0; i < LAST; i++) begin
                        stage_d[i] = stage_q[i+1];
                    end
                    if (fill_q != FULL) begin
                        fill_d = fill_q + (TW+1)'(1);
                    end
                end
                MODE_LOAD: begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_d[i] = load_data[i*WIDTH +: WIDTH];
                    end
                    fill_d = FULL;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            fill_q <= fill_d;
        end
    end

    // Out-of-range taps (non-power-of-2 DEPTH) clamp to the last stage.
    assign tap_k = (32'(tap_sel) > LAST) ? TW'(LAST) : tap_sel;

    assign data_out   = stage_q[tap_k];
    assign first_out  = stage_q[0];
    assign last_out   = stage_q[LAST];
    assign fill_count = fill_q;
    assign primed     = (fill_q > {1'b0, tap_k});

    always_comb begin
        par_out = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            par_out[i*WIDTH +: WIDTH] = stage_q[i];
        end
    end

endmodule

// File: doc/shift_line.md
SHIFT_LINE -- requirements
Module: shift_line

Interface
REQ-001 Parameter WIDTH, default 8: bits per stage; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: number of stages; SHALL be >= 2.
REQ-003 Parameter TW, default $clog2(DEPTH): width of tap_sel and fill_count-1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 clear  input  1  synchronous clear of stages and fill count.
REQ-007 en  input  1  cycle enable; 0 = hold regardless of mode.
REQ-008 mode  input  2  00 hold, 01 shift toward stage DEPTH-1, 10 shift toward stage 0, 11 parallel load.
REQ-009 data_in  input  WIDTH  serial word entering the shift.
REQ-010 load_data  input  WIDTH*DEPTH  parallel load image; bits [WIDTH*(i+1)-1:WIDTH*i] map to stage i.
REQ-011 tap_sel  input  TW  stage index driven on data_out.
REQ-012 data_out  output  WIDTH  contents of selected tap stage.
REQ-013 last_out  output  WIDTH  contents of stage DEPTH-1.
REQ-014 first_out  output  WIDTH  contents of stage 0.
REQ-015 par_out  output  WIDTH*DEPTH  all stages, same packing as load_data.
REQ-016 fill_count  output  TW+1  number of stages holding data written since reset/clear, 0..DEPTH.
REQ-017 primed  output  1  high when selected tap stage holds valid data.

Function
REQ-018 Stage registers s[0..DEPTH-1], each WIDTH bits; all outputs SHALL be combinational from registers (no extra output flop).
REQ-019 Priority each edge: clear, then en, then mode.
REQ-020 clear=1: all stages <= 0, fill_count <= 0, regardless of en/mode.
REQ-021 en=0 or mode=00: all state holds.
REQ-022 mode=01: s[0] <= data_in; s[i] <= s[i-1] for i=1..DEPTH-1; prior s[DEPTH-1] discarded.
REQ-023 mode=10: s[DEPTH-1] <= data_in; s[i] <= s[i+1] for i=0..DEPTH-2; prior s[0] discarded.
REQ-024 mode=11: s[i] <= load_data slice i for all i; fill_count <= DEPTH.
REQ-025 mode 01 or 10: fill_count <= fill_count+1, saturating at DEPTH (no wrap).
REQ-026 Effective tap k = tap_sel if tap_sel <= DEPTH-1, else DEPTH-1 (clamp, for non-power-of-2 DEPTH).
REQ-027 data_out = s[k]; tap_sel change SHALL take effect in the same cycle (combinational select).
REQ-028 Latency mode 01: word presented on data_in at edge n appears on data_out after edge n+k, i.e. k+1 shift edges; last_out after DEPTH shift edges.
REQ-029 primed = (fill_count > k) in mode-01 sense; SHALL be 1 whenever fill_count = DEPTH.
REQ-030 Enabled idle cycles (en=0) between shifts SHALL not affect latency counted in shift edges.
REQ-031 Mode change mid-stream: no flush; new mode applies to current stage contents on next enabled edge.

Reset
REQ-032 reset=0 SHALL asynchronously clear all stages to 0 and fill_count to 0; data_out, last_out, first_out, par_out = 0, primed = 0.
REQ-033 Reset deassertion SHALL be accepted without glitch; first state change occurs at first rising clk with reset=1.
REQ-034 reset asserted mid-shift SHALL discard all stage contents; no partial state survives.

Verification (WIDTH=8, DEPTH=4 unless noted)
REQ-035 Reset, then en=1 mode=01, data_in 0x11,0x22,0x33,0x44,0x55 on successive edges, tap_sel=3 -> last_out/data_out = 0x11 after 4th edge, 0x22 after 5th; primed rises after 4th edge; fill_count 1,2,3,4,4.
REQ-036 Shift 0xA1..0xA4 via mode=01, then mode=10 with data_in 0xFF one edge -> par_out stages 0..3 = 0xA3,0xA2,0xA1,0xFF; fill_count stays 4.
REQ-037 mode=11 load_data = {0x04,0x03,0x02,0x01} -> next cycle first_out 0x01, last_out 0x04, fill_count 4, primed 1; then en=0 three cycles -> no change.
REQ-038 After 2 mode-01 shifts, sweep tap_sel 0..3 in one cycle -> data_out follows combinationally; primed 1,1,0,0.
REQ-039 Mid-stream: clear=1 with en=1 mode=01 -> all stages 0, fill_count 0 (clear wins); separately reset pulse low between edges -> outputs 0 before next edge.
REQ-040 DEPTH=5, tap_sel=7 -> data_out = s[4] = last_out; fill_count never exceeds 5 after 8 shifts.
